// File: rtl/mul12_recursive_sched.sv
// mul12_recursive_sched: sequential 12x12 unsigned multiplier that reuses one
// 6x6 multiplier across the four half-word sub-products (LL, HL, LH, HH) and
// accumulates them into a 24-bit product. Valid/ready handshakes on both sides.
// Optional build macro: ZERO_SKIP_EN (a zero operand bypasses the MUL phase).

// Exact 6x6 unsigned multiplier shared by the controller below.
module mul6x6 (
  input  logic [5:0]  x,
  input  logic [5:0]  y,
  output logic [11:0] prod
);
  assign prod = {6'b0, x} * {6'b0, y};
endmodule

module mul12_recursive_sched #(
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] a,
  input  logic [11:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] p,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] acc_q, acc_d;
  logic [11:0] a_q, a_d;
  logic [11:0] b_q, b_d;

  logic [5:0]  mul_x, mul_y;
  logic [11:0] mul_prod;
  logic [23:0] pp_shifted;
  logic        accept;

  mul6x6 u_mul6x6 (
    .x    (mul_x),
    .y    (mul_y),
    .prod (mul_prod)
  );

  // Handshake outputs; in DONE a new pair can only enter alongside a consumed result.
  always_comb begin
    in_ready = 1'b0;
    if (state_q == IDLE) begin
      in_ready = 1'b1;
    end else if (state_q == DONE && BACK_TO_BACK) begin
      in_ready = out_ready;
    end
  end

  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == MUL);
  assign p         = acc_q;

  // Select the operand slices for this step and align the sub-product to its weight.
  always_comb begin
    mul_x      = a_q[5:0];
    mul_y      = b_q[5:0];
    pp_shifted = 24'd0;
    case (idx_q)
      2'd0: begin
        mul_x      = a_q[5:0];
        mul_y      = b_q[5:0];
        pp_shifted = {12'b0, mul_prod};
      end
      2'd1: begin
        mul_x      = a_q[11:6];
        mul_y      = b_q[5:0];
        pp_shifted = {6'b0, mul_prod, 6'b0};
      end
      2'd2: begin
        mul_x      = a_q[5:0];
        mul_y      = b_q[11:6];
        pp_shifted = {6'b0, mul_prod, 6'b0};
      end
      default: begin
        mul_x      = a_q[11:6];
        mul_y      = b_q[11:6];
        pp_shifted = {mul_prod, 12'b0};
      end
    endcase
  end

  // Next-state logic: accept new operands, step through the four sub-products, hold result.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      acc_d = 24'd0;
      idx_d = 2'd0;
`ifdef ZERO_SKIP_EN
      if (a == 12'd0 || b == 12'd0) begin
        state_d = DONE;
      end else begin
        state_d = MUL;
      end
`else
      state_d = MUL;
`endif
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        MUL: begin
          acc_d = acc_q + pp_shifted;
          idx_d = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous reset dropping any in-flight work.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      acc_q   <= 24'd0;
      a_q     <= 12'd0;
      b_q     <= 12'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

endmodule

// File: tb/tb_mul12_recursive_sched.sv
// Testbench for mul12_recursive_sched: one instance with BACK_TO_BACK=1 and one
// with BACK_TO_BACK=0, directed vectors with hand-computed products.
// Expectations for zero operands follow the ZERO_SKIP_EN build macro.
module tb_mul12_recursive_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [11:0] a = 12'd0, b = 12'd0;
  logic [23:0] p;

  logic        z_in_valid = 1'b0, z_in_ready, z_out_valid, z_out_ready = 1'b0, z_busy;
  logic [11:0] z_a = 12'd0, z_b = 12'd0;
  logic [23:0] z_p;

  int total = 0;
  int bad   = 0;

  mul12_recursive_sched #(.BACK_TO_BACK(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  mul12_recursive_sched #(.BACK_TO_BACK(1'b0)) dut_nb2b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (z_in_valid),
    .in_ready  (z_in_ready),
    .a         (z_a),
    .b         (z_b),
    .out_valid (z_out_valid),
    .out_ready (z_out_ready),
    .p         (z_p),
    .busy      (z_busy)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
    total++;
    if (p !== 24'd0) begin bad++; $display("[TB] FAIL reset_p got=%h want=000000", p); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    total++;
    if (z_in_ready !== 1'b1 || z_out_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_nb2b got in_ready=%b out_valid=%b want 1/0", z_in_ready, z_out_valid);
    end
  endtask

  // One full transaction on the BACK_TO_BACK=1 instance with latency and busy-cycle checks.
  task automatic do_mul(input logic [11:0] ta, input logic [11:0] tb, input logic [23:0] exp_p,
                        input int exp_lat, input int exp_busy, input string name);
    int n;
    int busy_cnt;
    a = ta;
    b = tb;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL %s_ready got=%b want=1", name, in_ready); end
    step();
    in_valid = 1'b0;
    n = 1;
    busy_cnt = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      if (busy === 1'b1) busy_cnt++;
      step();
      n++;
    end
    total++;
    if (n !== exp_lat) begin bad++; $display("[TB] FAIL %s_latency got=%0d want=%0d", name, n, exp_lat); end
    total++;
    if (busy_cnt !== exp_busy) begin bad++; $display("[TB] FAIL %s_busy_cycles got=%0d want=%0d", name, busy_cnt, exp_busy); end
    total++;
    if (p !== exp_p) begin bad++; $display("[TB] FAIL %s_p got=%h want=%h", name, p, exp_p); end
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL %s_to_idle got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_basic();
    do_mul(12'd3,   12'd5,   24'd15,      5, 4, "mul_3x5");
    do_mul(12'hFFF, 12'hFFF, 24'hFFE001,  5, 4, "mul_max");
    do_mul(12'h800, 12'h800, 24'h400000,  5, 4, "mul_msb");
    do_mul(12'h123, 12'h456, 24'h04EDC2,  5, 4, "mul_mixed");
  endtask

  task automatic test_backpressure();
    int n;
    a = 12'h123;
    b = 12'h456;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    step();
    a = 12'h00F;
    b = 12'h00F;
    n = 1;
    while (out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    total++;
    if (n !== 5) begin bad++; $display("[TB] FAIL bp_latency got=%0d want=5", n); end
    for (int i = 0; i < 7; i++) begin
      total++;
      if (out_valid !== 1'b1 || p !== 24'h04EDC2 || in_ready !== 1'b0) begin
        bad++;
        $display("[TB] FAIL bp_hold_%0d got out_valid=%b p=%h in_ready=%b want 1/04edc2/0", i, out_valid, p, in_ready);
      end
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    total++;
    if (out_valid !== 1'b1 || p !== 24'h04EDC2) begin
      bad++; $display("[TB] FAIL bp_release got out_valid=%b p=%h want 1/04edc2", out_valid, p);
    end
    step();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL bp_idle got out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    step();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_single_handshake got out_valid=%b want 0", out_valid); end
  endtask

  // Both instances fed continuously; results and their spacing are checked per instance.
  task automatic test_back_to_back();
    logic [11:0] pa [3];
    logic [11:0] pb [3];
    logic [23:0] pe [3];
    logic [23:0] got1 [3];
    logic [23:0] got0 [3];
    int t1 [3];
    int t0 [3];
    int k1, k0, r1, r0;
    logic acc1, acc0;
    pa = '{12'd1, 12'd2, 12'hFFF};
    pb = '{12'd1, 12'd3, 12'd1};
    pe = '{24'd1, 24'd6, 24'h000FFF};
    for (int i = 0; i < 3; i++) begin
      got1[i] = 24'd0; got0[i] = 24'd0; t1[i] = 0; t0[i] = 0;
    end
    k1 = 0; k0 = 0; r1 = 0; r0 = 0;
    a = pa[0]; b = pb[0]; in_valid = 1'b1; out_ready = 1'b1;
    z_a = pa[0]; z_b = pb[0]; z_in_valid = 1'b1; z_out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (r1 < 3 || r0 < 3); cyc++) begin
      if (out_valid === 1'b1 && r1 < 3) begin got1[r1] = p; t1[r1] = cyc; r1++; end
      if (z_out_valid === 1'b1 && r0 < 3) begin got0[r0] = z_p; t0[r0] = cyc; r0++; end
      acc1 = in_valid && in_ready;
      acc0 = z_in_valid && z_in_ready;
      step();
      if (acc1) begin
        k1++;
        if (k1 < 3) begin a = pa[k1]; b = pb[k1]; end else in_valid = 1'b0;
      end
      if (acc0) begin
        k0++;
        if (k0 < 3) begin z_a = pa[k0]; z_b = pb[k0]; end else z_in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    z_in_valid = 1'b0;
    total++;
    if (r1 !== 3 || r0 !== 3) begin bad++; $display("[TB] FAIL b2b_count got b2b=%0d nb2b=%0d want 3/3", r1, r0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (got1[i] !== pe[i]) begin bad++; $display("[TB] FAIL b2b_result_%0d got=%h want=%h", i, got1[i], pe[i]); end
      total++;
      if (got0[i] !== pe[i]) begin bad++; $display("[TB] FAIL nb2b_result_%0d got=%h want=%h", i, got0[i], pe[i]); end
    end
    for (int i = 1; i < 3; i++) begin
      total++;
      if (t1[i] - t1[i-1] !== 5) begin bad++; $display("[TB] FAIL b2b_spacing_%0d got=%0d want=5", i, t1[i] - t1[i-1]); end
      total++;
      if (t0[i] - t0[i-1] !== 6) begin bad++; $display("[TB] FAIL nb2b_spacing_%0d got=%0d want=6", i, t0[i] - t0[i-1]); end
    end
    step();
    step();
    total++;
    if (in_ready !== 1'b1 || z_in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL b2b_idle got in_ready=%b nb2b_in_ready=%b want 1/1", in_ready, z_in_ready);
    end
  endtask

  task automatic test_reset_mid();
    a = 12'd3;
    b = 12'd5;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    total++;
    if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rstmid_busy got=%b want=1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (out_valid !== 1'b0 || p !== 24'd0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rstmid_state got out_valid=%b p=%h in_ready=%b busy=%b want 0/000000/1/0", out_valid, p, in_ready, busy);
    end
    do_mul(12'd7, 12'd9, 24'd63, 5, 4, "after_rst");
  endtask

  task automatic test_zero_operand();
`ifdef ZERO_SKIP_EN
    do_mul(12'd0, 12'hABC, 24'd0, 1, 0, "zero_a");
    do_mul(12'h5A5, 12'd0, 24'd0, 1, 0, "zero_b");
`else
    do_mul(12'd0, 12'hABC, 24'd0, 5, 4, "zero_a");
    do_mul(12'h5A5, 12'd0, 24'd0, 5, 4, "zero_b");
`endif
  endtask

  // Run the scenarios in order and report.
  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero_operand();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
